arb_rr_2to1: RTL and testbench
==============================

Name: arb_rr_2to1

Overview:
- Two-input round-robin stream arbiter with a registered output stage, WIDTH bits wide.
- Sits directly upstream of mux_2to1 in the catalog datapath. It picks which of two valid/ready sources goes forward, registers that source's data, and exports the registered select.
- Downstream logic consumes out_data/out_valid and may also drive a mux_2to1 select from out_sel.
- Replaces a free-running combinational select with a handshaked, fair, one-cycle pipeline stage.

Parameters:
- WIDTH, 4, data width of each input and of the output.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- a_valid  input  1  source A has a data word.
- a_data  input  WIDTH  source A data.
- a_ready  output  1  A's word is accepted this cycle.
- b_valid  input  1  source B has a data word.
- b_data  input  WIDTH  source B data.
- b_ready  output  1  B's word is accepted this cycle.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered winning data.
- out_sel  output  1  registered source of out_data: 0 = A, 1 = B.
- out_ready  input  1  downstream accepts the word this cycle.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. Nothing is asynchronous.
- Reset (rst=1 at a rising edge):
  - out_valid=0, out_data=0, out_sel=0.
  - Priority pointer last=1 (B granted last), so A wins the first tie.
  - rst overrides any transfer in that cycle; a word held in the output register is dropped.
- Load enable: load = !out_valid || out_ready. This is combinational and allows full throughput of one word per clock.
- Grant, combinational, evaluated only when load=1:
  - only a_valid → grant A;
  - only b_valid → grant B;
  - both valid → grant the source not equal to last;
  - neither valid → no grant.
- Ready outputs:
  - a_ready = load && grant==A.
  - b_ready = load && grant==B.
  - At most one ready is high in any cycle. Ready never asserts while rst=1.
- Register update on the clock edge with load=1:
  - With a grant: out_data ← granted data, out_sel ← granted id, out_valid ← 1, last ← granted id.
  - Without a grant: out_valid ← 0; out_data/out_sel hold their values; last unchanged.
- Stall (out_valid=1, out_ready=0): out_data, out_sel, out_valid and last hold; a_ready=b_ready=0.
- Latency: exactly 1 cycle from input handshake to out_valid. Throughput 1 word/cycle. With both sources continuously valid and out_ready=1, the grants strictly alternate A,B,A,B…
- last updates only on an accepted transfer. A lone requester does not shift fairness.
- Inputs follow valid/ready rules: a source holds valid and data stable until it sees ready. The arbiter does not depend on this for correctness, but the bench checks it.
- out_ready may be high while out_valid=0; it has no effect beyond enabling load.
- Transfers are word-granular; there is no lock or burst mode.

Test Plan:
- Reset: hold rst=1 for 2 cycles with a_valid=b_valid=1 → a_ready=b_ready=0 throughout; afterwards out_valid=0, out_data=4'b0000, out_sel=0.
- Single source: a_valid=1, a_data=4'b0101, b_valid=0, out_ready=1 → a_ready=1 that cycle; next cycle out_valid=1, out_data=4'b0101, out_sel=0.
- Tie fairness: both valid, a_data=4'b0011, b_data=4'b1100, out_ready=1 for 4 cycles after reset → out_sel sequence 0,1,0,1 and out_data sequence 0011,1100,0011,1100.
- Backpressure: output holding 4'b1010 (sel=1), out_ready=0 for 3 cycles with both valid → out_data/out_sel/out_valid stable, both readies 0. Then out_ready=1 → A granted, because last=B.
- Drain: single word accepted, then a_valid=b_valid=0 with out_ready=1 → out_valid drops to 0 the cycle after the consumption, and last is unchanged (verified by the next tie's winner).
- Mid-operation reset: out_valid=1, out_ready=0, assert rst for 1 cycle → out_valid=0, out_data=0. The first tie afterwards grants A.

Source files
------------

// File: rtl/arb_rr_2to1_if.sv
// Handshake bundle for the 2:1 round-robin arbiter: two valid/ready sources
// and one registered valid/ready output with its source select.
interface arb_rr_2to1_if #(
  parameter int WIDTH = 4
);
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_sel;
  logic             out_ready;

  // The master side drives the sources and the downstream ready.
  modport master (
    output a_valid, a_data, b_valid, b_data, out_ready,
    input  a_ready, b_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data, out_ready,
    output a_ready, b_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/arb_rr_2to1.sv
// Two-input round-robin stream arbiter with a registered output stage.
// The winner's data and id are captured in one cycle; fairness follows the last accepted source.
module arb_rr_2to1 #(
  parameter int WIDTH = 4
) (
  input logic          clk,
  input logic          rst,
  arb_rr_2to1_if.slave bus
);
  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_t;

  src_t             last;
  src_t             out_sel_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;

  logic             load;
  logic             grant_valid;
  src_t             grant_id;

  assign load = !out_valid_q || bus.out_ready;

  // On a tie the source that did not win last time goes first.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = SRC_A;
    if (load) begin
      case ({bus.a_valid, bus.b_valid})
        2'b10: begin
          grant_valid = 1'b1;
          grant_id    = SRC_A;
        end
        2'b01: begin
          grant_valid = 1'b1;
          grant_id    = SRC_B;
        end
        2'b11: begin
          grant_valid = 1'b1;
          grant_id    = (last == SRC_A) ? SRC_B : SRC_A;
        end
        default: begin
          grant_valid = 1'b0;
          grant_id    = SRC_A;
        end
      endcase
    end
  end

  assign bus.a_ready = !rst && grant_valid && (grant_id == SRC_A);
  assign bus.b_ready = !rst && grant_valid && (grant_id == SRC_B);

  // Reset starts with B as last winner so A takes the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= SRC_A;
      last        <= SRC_B;
    end else if (load) begin
      if (grant_valid) begin
        out_valid_q <= 1'b1;
        out_data_q  <= (grant_id == SRC_A) ? bus.a_data : bus.b_data;
        out_sel_q   <= grant_id;
        last        <= grant_id;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_arb_rr_2to1.sv
// Self-checking bench for arb_rr_2to1: directed scenarios followed by
// randomized traffic, all compared against a round-robin reference model.
module tb_arb_rr_2to1;
  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  arb_rr_2to1_if #(.WIDTH(WIDTH)) bus ();

  arb_rr_2to1 #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model: what the output register holds and who won last.
  bit         mValid;
  logic [3:0] mData;
  int         mSel;
  int         mLast;
  bit         expA;
  bit         expB;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Scan forward from the last winner; the first requester found wins.
  function automatic int pickWinner(input bit reqA, input bit reqB, input int lastId);
    bit req[2];
    req[0] = reqA;
    req[1] = reqB;
    for (int k = 1; k <= 2; k++) begin
      int c;
      c = (lastId + k) % 2;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  // Drive one cycle of inputs, check readies before the edge and outputs after it.
  task automatic applyStimulus(input bit r, input bit aV, input logic [3:0] aD,
                               input bit bV, input logic [3:0] bD, input bit oR);
    int w;
    bit load;
    @(negedge clk);
    rst           = r;
    bus.a_valid   = aV;
    bus.a_data    = aD;
    bus.b_valid   = bV;
    bus.b_data    = bD;
    bus.out_ready = oR;
    #1;
    load = !mValid || oR;
    w    = pickWinner(aV, bV, mLast);
    expA = !r && load && (w == 0);
    expB = !r && load && (w == 1);
    checkOutput("a_ready", {31'd0, bus.a_ready}, {31'd0, expA});
    checkOutput("b_ready", {31'd0, bus.b_ready}, {31'd0, expB});
    @(posedge clk);
    if (r) begin
      mValid = 1'b0;
      mData  = 4'd0;
      mSel   = 0;
      mLast  = 1;
    end else if (load) begin
      if (w >= 0) begin
        mValid = 1'b1;
        mData  = (w == 0) ? aD : bD;
        mSel   = w;
        mLast  = w;
      end else begin
        mValid = 1'b0;
      end
    end
    #1;
    checkOutput("out_valid", {31'd0, bus.out_valid}, {31'd0, mValid});
    checkOutput("out_data", {28'd0, bus.out_data}, {28'd0, mData});
    checkOutput("out_sel", {31'd0, bus.out_sel}, mSel);
  endtask

  initial begin
    int         tieSel[4];
    bit         aPend;
    bit         bPend;
    logic [3:0] aD;
    logic [3:0] bD;
    bit         r;
    bit         oR;

    rst           = 1'b1;
    bus.a_valid   = 1'b0;
    bus.a_data    = 4'd0;
    bus.b_valid   = 1'b0;
    bus.b_data    = 4'd0;
    bus.out_ready = 1'b0;
    mValid        = 1'b0;
    mData         = 4'd0;
    mSel          = 0;
    mLast         = 1;

    // Reset held with both sources requesting.
    applyStimulus(1, 1, 4'h5, 1, 4'h6, 1);
    applyStimulus(1, 1, 4'h5, 1, 4'h6, 1);
    checkOutput("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("rst_out_data", {28'd0, bus.out_data}, 32'd0);
    checkOutput("rst_out_sel", {31'd0, bus.out_sel}, 32'd0);

    // Lone source A.
    applyStimulus(0, 1, 4'b0101, 0, 4'h0, 1);
    checkOutput("single_data", {28'd0, bus.out_data}, 32'h5);
    checkOutput("single_sel", {31'd0, bus.out_sel}, 32'd0);

    // Tie fairness from a fresh reset.
    applyStimulus(1, 0, 4'h0, 0, 4'h0, 1);
    tieSel = '{0, 1, 0, 1};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 4'b0011, 1, 4'b1100, 1);
      checkOutput("tie_sel", {31'd0, bus.out_sel}, tieSel[i]);
      checkOutput("tie_data", {28'd0, bus.out_data}, (tieSel[i] == 0) ? 32'h3 : 32'hC);
    end

    // Backpressure while holding a word from B.
    applyStimulus(1, 0, 4'h0, 0, 4'h0, 1);
    applyStimulus(0, 0, 4'h0, 1, 4'b1010, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 4'b0011, 1, 4'b1010, 0);
      checkOutput("stall_data", {28'd0, bus.out_data}, 32'hA);
      checkOutput("stall_sel", {31'd0, bus.out_sel}, 32'd1);
    end
    applyStimulus(0, 1, 4'b0011, 1, 4'b1010, 1);
    checkOutput("after_stall_sel", {31'd0, bus.out_sel}, 32'd0);

    // Drain, then confirm fairness pointer via the next tie.
    applyStimulus(1, 0, 4'h0, 0, 4'h0, 1);
    applyStimulus(0, 1, 4'h7, 0, 4'h0, 1);
    applyStimulus(0, 0, 4'h0, 0, 4'h0, 1);
    checkOutput("drain_valid", {31'd0, bus.out_valid}, 32'd0);
    applyStimulus(0, 0, 4'h0, 0, 4'h0, 1);
    applyStimulus(0, 1, 4'h2, 1, 4'h9, 1);
    checkOutput("drain_tie_sel", {31'd0, bus.out_sel}, 32'd1);

    // Reset in the middle of a stall.
    applyStimulus(0, 1, 4'h4, 0, 4'h0, 0);
    applyStimulus(0, 1, 4'h4, 0, 4'h0, 0);
    applyStimulus(1, 1, 4'h4, 1, 4'h5, 0);
    checkOutput("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("mid_rst_data", {28'd0, bus.out_data}, 32'd0);
    applyStimulus(0, 1, 4'b0011, 1, 4'b1100, 1);
    checkOutput("mid_rst_tie_sel", {31'd0, bus.out_sel}, 32'd0);

    // Random traffic; sources hold valid/data until accepted.
    aPend = 1'b0;
    bPend = 1'b0;
    aD    = 4'd0;
    bD    = 4'd0;
    for (int n = 0; n < 600; n++) begin
      r = ($urandom_range(0, 49) == 0);
      if (!aPend) begin
        aPend = ($urandom_range(0, 2) != 0);
        aD    = 4'($urandom);
      end
      if (!bPend) begin
        bPend = ($urandom_range(0, 2) != 0);
        bD    = 4'($urandom);
      end
      oR = ($urandom_range(0, 3) != 0);
      applyStimulus(r, aPend, aD, bPend, bD, oR);
      if (expA) aPend = 1'b0;
      if (expB) bPend = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
